// File: rtl/bht_sched_pkg.sv
// Shared types for the BHT access scheduler: FSM state and update-queue entry.
package bht_sched_pkg;

  localparam int BHT_IWIDTH = 6;

  typedef enum logic {
    SWEEP,
    RUN
  } state_e;

  typedef struct packed {
    logic [BHT_IWIDTH-1:0] index;
    logic                  taken;
  } upd_entry_t;

endpackage

// File: rtl/bht_upd_fifo.sv
// Synchronous FIFO of pending history updates with flush and occupancy count.
module bht_upd_fifo
  import bht_sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     resetn_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  upd_entry_t               din_i,
  output upd_entry_t               dout_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output logic                     full_o
);

  localparam int PW = $clog2(DEPTH);

  upd_entry_t    mem_q [DEPTH];
  logic [PW-1:0] rd_q, wr_q;
  logic [PW:0]   cnt_q;

  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_q] <= din_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i)  rd_q <= rd_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign dout_o  = mem_q[rd_q];
  assign count_o = cnt_q;
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (PW+1)'(DEPTH));

endmodule

// File: rtl/bht_sched.sv
// Single-port BHT scheduler: post-reset/clear zeroing sweep, lookup vs. queued update arbitration.
// Define BHT_SCHED_STARVE_EN to enable the update starvation guard.
module bht_sched
  import bht_sched_pkg::*;
#(
  parameter int IWIDTH = BHT_IWIDTH,
  parameter int HWIDTH = 6,
  parameter int QDEPTH = 4,
  parameter int STARVE = 8
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      en,
  input  logic                      clear,
  input  logic                      lookup_valid,
  input  logic [IWIDTH-1:0]         lookup_index,
  output logic                      lookup_ready,
  output logic [HWIDTH-1:0]         lookup_hist,
  input  logic                      upd_valid,
  input  logic [IWIDTH-1:0]         upd_index,
  input  logic                      upd_taken,
  output logic                      upd_ready,
  output logic [IWIDTH-1:0]         tbl_addr,
  output logic                      tbl_we,
  output logic [HWIDTH-1:0]         tbl_wdata,
  input  logic [HWIDTH-1:0]         tbl_rdata,
  output logic                      busy,
  output logic [$clog2(QDEPTH):0]   qcount
);

  state_e            state_q, state_d;
  logic [IWIDTH-1:0] sweep_q, sweep_d;
  logic              push, pop, flush, force_upd;
  logic              fifo_empty, fifo_full;
  upd_entry_t        head, push_entry;

  assign push_entry.index = BHT_IWIDTH'(upd_index);
  assign push_entry.taken = upd_taken;

  bht_upd_fifo #(.DEPTH(QDEPTH)) u_fifo (
    .clk_i    (clk),
    .resetn_i (resetn),
    .push_i   (push),
    .pop_i    (pop),
    .flush_i  (flush),
    .din_i    (push_entry),
    .dout_o   (head),
    .count_o  (qcount),
    .empty_o  (fifo_empty),
    .full_o   (fifo_full)
  );

`ifdef BHT_SCHED_STARVE_EN
  localparam int SW = $clog2(STARVE + 1);
  logic [SW-1:0] starve_q, starve_d;

  always_comb begin
    starve_d = starve_q;
    if (en) begin
      if (clear || state_q != RUN || fifo_empty || pop) starve_d = '0;
      else if (!force_upd)                              starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) starve_q <= '0;
    else         starve_q <= starve_d;
  end

  assign force_upd = (starve_q >= SW'(STARVE));
`else
  assign force_upd = 1'b0;
`endif

  assign lookup_hist = tbl_rdata;

  // A clear cycle never services the queue, so flushed entries are never written.
  always_comb begin
    state_d      = state_q;
    sweep_d      = sweep_q;
    tbl_addr     = fifo_empty ? '0 : IWIDTH'(head.index);
    tbl_we       = 1'b0;
    tbl_wdata    = '0;
    lookup_ready = 1'b0;
    upd_ready    = 1'b0;
    busy         = (state_q == SWEEP);
    push         = 1'b0;
    pop          = 1'b0;
    flush        = 1'b0;
    if (state_q == SWEEP) begin
      tbl_addr = sweep_q;
      if (en) begin
        tbl_we  = 1'b1;
        sweep_d = sweep_q + 1'b1;
        if (sweep_q == '1) state_d = RUN;
      end
    end else if (en) begin
      upd_ready = !clear && !fifo_full;
      push      = upd_valid && upd_ready;
      if (lookup_valid && !force_upd) begin
        lookup_ready = 1'b1;
        tbl_addr     = lookup_index;
      end else if (!fifo_empty && !clear) begin
        pop       = 1'b1;
        tbl_we    = 1'b1;
        tbl_wdata = {tbl_rdata[HWIDTH-2:0], head.taken};
      end
    end
    if (en && clear) begin
      flush   = 1'b1;
      state_d = SWEEP;
      sweep_d = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= SWEEP;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

endmodule

// File: tb/tb_bht_sched.sv
// Directed self-checking bench for bht_sched with a behavioural 64x6 table model.
module tb_bht_sched;

  localparam int IW = 6;
  localparam int HW = 6;
  localparam int QD = 4;
  localparam int ST = 8;

  logic          clk = 1'b0;
  logic          resetn, en, clear;
  logic          lookup_valid, lookup_ready;
  logic [IW-1:0] lookup_index;
  logic [HW-1:0] lookup_hist;
  logic          upd_valid, upd_taken, upd_ready;
  logic [IW-1:0] upd_index;
  logic [IW-1:0] tbl_addr;
  logic          tbl_we;
  logic [HW-1:0] tbl_wdata, tbl_rdata;
  logic          busy;
  logic [2:0]    qcount;

  logic [HW-1:0] tbl [2**IW];

  int checks   = 0;
  int failures = 0;
  int nonzero;

  always #5 clk = ~clk;

  bht_sched #(.IWIDTH(IW), .HWIDTH(HW), .QDEPTH(QD), .STARVE(ST)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .en           (en),
    .clear        (clear),
    .lookup_valid (lookup_valid),
    .lookup_index (lookup_index),
    .lookup_ready (lookup_ready),
    .lookup_hist  (lookup_hist),
    .upd_valid    (upd_valid),
    .upd_index    (upd_index),
    .upd_taken    (upd_taken),
    .upd_ready    (upd_ready),
    .tbl_addr     (tbl_addr),
    .tbl_we       (tbl_we),
    .tbl_wdata    (tbl_wdata),
    .tbl_rdata    (tbl_rdata),
    .busy         (busy),
    .qcount       (qcount)
  );

  // Table model is preloaded with garbage while in reset so the sweep has to clear it.
  assign tbl_rdata = tbl[tbl_addr];
  always @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < 2**IW; i++) tbl[i] <= 6'h2A;
    end else if (tbl_we) begin
      tbl[tbl_addr] <= tbl_wdata;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic lv, input logic [IW-1:0] li,
                               input logic uv, input logic [IW-1:0] ui, input logic ut);
    lookup_valid = lv;
    lookup_index = li;
    upd_valid    = uv;
    upd_index    = ui;
    upd_taken    = ut;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic countNonzero;
    nonzero = 0;
    for (int i = 0; i < 2**IW; i++) if (tbl[i] !== '0) nonzero++;
  endtask

  initial begin
    resetn = 1'b0; en = 1'b1; clear = 1'b0;
    lookup_valid = 1'b0; lookup_index = '0;
    upd_valid = 1'b0; upd_index = '0; upd_taken = 1'b0;
    #2;
    checkOutput("rst_busy",   32'(busy),         32'd1);
    checkOutput("rst_we",     32'(tbl_we),       32'd1);
    checkOutput("rst_addr",   32'(tbl_addr),     32'd0);
    checkOutput("rst_wdata",  32'(tbl_wdata),    32'd0);
    checkOutput("rst_lrdy",   32'(lookup_ready), 32'd0);
    checkOutput("rst_urdy",   32'(upd_ready),    32'd0);
    checkOutput("rst_qcount", 32'(qcount),       32'd0);

    @(negedge clk);
    resetn = 1'b1;
    #1;
    for (int i = 0; i < 2**IW; i++) begin
      if (i == 20) begin
        en = 1'b0;
        repeat (5) begin
          #1;
          checkOutput("pause_we",   32'(tbl_we),   32'd0);
          checkOutput("pause_addr", 32'(tbl_addr), 32'd20);
          checkOutput("pause_busy", 32'(busy),     32'd1);
          tick();
        end
        en = 1'b1;
        #1;
      end
      checkOutput("sweep_busy",  32'(busy),      32'd1);
      checkOutput("sweep_addr",  32'(tbl_addr),  32'(i));
      checkOutput("sweep_we",    32'(tbl_we),    32'd1);
      checkOutput("sweep_wdata", 32'(tbl_wdata), 32'd0);
      checkOutput("sweep_urdy",  32'(upd_ready), 32'd0);
      tick();
    end
    checkOutput("run_busy", 32'(busy),      32'd0);
    checkOutput("run_urdy", 32'(upd_ready), 32'd1);
    checkOutput("run_we",   32'(tbl_we),    32'd0);
    countNonzero();
    checkOutput("sweep_zero", 32'(nonzero), 32'd0);

    // Two updates to index 5, then a lookup of it.
    applyStimulus(1'b0, '0, 1'b1, 6'd5, 1'b1);
    checkOutput("u5a_urdy", 32'(upd_ready), 32'd1);
    tick();
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
    checkOutput("u5a_q",     32'(qcount),    32'd1);
    checkOutput("u5a_we",    32'(tbl_we),    32'd1);
    checkOutput("u5a_addr",  32'(tbl_addr),  32'd5);
    checkOutput("u5a_wdata", 32'(tbl_wdata), 32'b000001);
    tick();
    applyStimulus(1'b0, '0, 1'b1, 6'd5, 1'b0);
    checkOutput("u5b_q", 32'(qcount), 32'd0);
    tick();
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
    checkOutput("u5b_wdata", 32'(tbl_wdata), 32'b000010);
    tick();
    applyStimulus(1'b1, 6'd5, 1'b0, '0, 1'b0);
    checkOutput("lk5_rdy",  32'(lookup_ready), 32'd1);
    checkOutput("lk5_hist", 32'(lookup_hist),  32'b000010);
    checkOutput("lk5_we",   32'(tbl_we),       32'd0);
    checkOutput("lk5_addr", 32'(tbl_addr),     32'd5);
    tick();

    // Back-to-back taken updates to index 9 must compose through the table.
    applyStimulus(1'b0, '0, 1'b1, 6'd9, 1'b1);
    tick();
    applyStimulus(1'b0, '0, 1'b1, 6'd9, 1'b1);
    checkOutput("u9a_wdata", 32'(tbl_wdata), 32'b000001);
    checkOutput("u9a_urdy",  32'(upd_ready), 32'd1);
    tick();
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
    checkOutput("u9b_q",     32'(qcount),    32'd1);
    checkOutput("u9b_wdata", 32'(tbl_wdata), 32'b000011);
    tick();
    checkOutput("u9_drain", 32'(qcount), 32'd0);

    // Fill the queue behind a stream of lookups; a fifth offer is held.
    for (int k = 0; k < QD; k++) begin
      applyStimulus(1'b1, '0, 1'b1, IW'(10 + k), 1'b1);
      checkOutput("fill_urdy", 32'(upd_ready), 32'd1);
      tick();
    end
    applyStimulus(1'b1, '0, 1'b1, 6'd14, 1'b1);
    checkOutput("full_q",    32'(qcount),       32'd4);
    checkOutput("full_urdy", 32'(upd_ready),    32'd0);
    checkOutput("full_lrdy", 32'(lookup_ready), 32'd1);
    tick();
    checkOutput("full_urdy2", 32'(upd_ready), 32'd0);
    applyStimulus(1'b0, '0, 1'b1, 6'd14, 1'b1);
    checkOutput("pop10_we",   32'(tbl_we),    32'd1);
    checkOutput("pop10_addr", 32'(tbl_addr),  32'd10);
    checkOutput("pop10_urdy", 32'(upd_ready), 32'd0);
    tick();
    checkOutput("after_pop_q",    32'(qcount),    32'd3);
    checkOutput("after_pop_urdy", 32'(upd_ready), 32'd1);
    checkOutput("after_pop_addr", 32'(tbl_addr),  32'd11);
    tick();
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
    checkOutput("pushpop_q", 32'(qcount), 32'd3);
    for (int w = 0; w < 10; w++) begin
      if (qcount == '0) break;
      tick();
    end
    checkOutput("fill_drain", 32'(qcount), 32'd0);

    // One queued update against continuous lookups.
    applyStimulus(1'b1, '0, 1'b1, 6'd20, 1'b1);
    checkOutput("stv_push_lrdy", 32'(lookup_ready), 32'd1);
    tick();
    applyStimulus(1'b1, '0, 1'b0, '0, 1'b0);
    checkOutput("stv_q", 32'(qcount), 32'd1);
    for (int g = 0; g < ST; g++) begin
      checkOutput("stv_grant", 32'(lookup_ready), 32'd1);
      checkOutput("stv_we",    32'(tbl_we),       32'd0);
      tick();
    end
`ifdef BHT_SCHED_STARVE_EN
    checkOutput("stv_force_lrdy",  32'(lookup_ready), 32'd0);
    checkOutput("stv_force_we",    32'(tbl_we),       32'd1);
    checkOutput("stv_force_addr",  32'(tbl_addr),     32'd20);
    checkOutput("stv_force_wdata", 32'(tbl_wdata),    32'b000001);
    tick();
    checkOutput("stv_force_q", 32'(qcount), 32'd0);
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
`else
    repeat (20) begin
      checkOutput("stv_strict_we", 32'(tbl_we), 32'd0);
      tick();
    end
    checkOutput("stv_strict_q", 32'(qcount), 32'd1);
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
    checkOutput("stv_late_we",   32'(tbl_we),   32'd1);
    checkOutput("stv_late_addr", 32'(tbl_addr), 32'd20);
    tick();
    checkOutput("stv_late_q", 32'(qcount), 32'd0);
`endif

    // Clear with three queued updates: nothing queued may reach the table.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, '0, 1'b1, IW'(30 + k), 1'b1);
      tick();
    end
    clear = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0);
    checkOutput("clr_q",    32'(qcount),    32'd3);
    checkOutput("clr_urdy", 32'(upd_ready), 32'd0);
    checkOutput("clr_we",   32'(tbl_we),    32'd0);
    tick();
    clear = 1'b0;
    #1;
    checkOutput("clr_q0",   32'(qcount),   32'd0);
    checkOutput("clr_busy", 32'(busy),     32'd1);
    for (int i = 0; i < 2**IW; i++) begin
      checkOutput("resweep_addr",  32'(tbl_addr),  32'(i));
      checkOutput("resweep_we",    32'(tbl_we),    32'd1);
      checkOutput("resweep_wdata", 32'(tbl_wdata), 32'd0);
      tick();
    end
    checkOutput("resweep_busy", 32'(busy),   32'd0);
    checkOutput("resweep_we0",  32'(tbl_we), 32'd0);
    checkOutput("resweep_q",    32'(qcount), 32'd0);
    countNonzero();
    checkOutput("resweep_zero", 32'(nonzero), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bht_sched.md
# bht_sched

Access scheduler for a single-ported branch history table (BHT). It sits between fetch-stage history lookups and execute-stage resolved-branch updates. It queues updates, arbitrates the one table port per cycle, and performs the shift-in read-modify-write. It also sequences a zeroing sweep of the table after reset and on `clear`. The table is external, with combinational read and a synchronous write on the same address.

## Interface
- `IWIDTH`, 6, table index width; table has 2**IWIDTH entries
- `HWIDTH`, 6, history record width, ≥2
- `QDEPTH`, 4, update queue depth, power of two ≥2
- `STARVE`, 8, consecutive update-denied cycles before an update is forced
- `clk` in 1, clock; all state updates on posedge
- `resetn` in 1, asynchronous, active-low reset
- `en` in 1, global stall: when low, all state frozen, `tbl_we`=0, `lookup_ready`=0, `upd_ready`=0
- `clear` in 1, request flush: drop the queue and re-sweep the table
- `lookup_valid` in 1, fetch requests history
- `lookup_index` in IWIDTH, index to read
- `lookup_ready` out 1, lookup granted this cycle
- `lookup_hist` out HWIDTH, history for a granted lookup; equals `tbl_rdata`
- `upd_valid` in 1, resolved branch offered
- `upd_index` in IWIDTH, index of resolved branch
- `upd_taken` in 1, outcome
- `upd_ready` out 1, queue accepts the offered update
- `tbl_addr` out IWIDTH, table port address
- `tbl_we` out 1, table write enable
- `tbl_wdata` out HWIDTH, table write data
- `tbl_rdata` in HWIDTH, combinational read of `tbl[tbl_addr]`
- `busy` out 1, sweep in progress
- `qcount` out $clog2(QDEPTH)+1, queued update count

## Operation
- FSM states are SWEEP and RUN. Reset enters SWEEP with the sweep counter at 0.
- In SWEEP: `tbl_addr` = sweep counter, `tbl_we`=1, `tbl_wdata`=0, `busy`=1, and both readies are 0. The counter increments each enabled cycle. After writing entry 2**IWIDTH−1, the FSM moves to RUN.
- `clear` (sampled with `en`=1) in any state: the queue empties, the sweep counter goes to 0, and the FSM moves to SWEEP. `upd_ready` is 0 in any cycle where `clear`=1.
- In RUN, the port is granted to lookup or update:
  - The update path is eligible when the queue is non-empty.
  - Lookup has priority: `lookup_ready` = `lookup_valid` && !force.
  - The update is serviced when eligible and (`lookup_valid`=0 or force).
- A serviced update pops the queue head and drives `tbl_addr`=head.index, `tbl_we`=1, `tbl_wdata` = {`tbl_rdata`[HWIDTH−2:0], head.taken}.
- A granted lookup drives `tbl_addr`=`lookup_index` and `tbl_we`=0.
- Idle port: `tbl_addr` = queue head index (or 0 if empty), `tbl_we`=0.
- Queue acceptance: `upd_ready` = RUN && `en` && !`clear` && `qcount`<QDEPTH. There is no accept-when-full, even with a pop in the same cycle.
- Push and pop may occur in the same cycle when not full; `qcount` is then unchanged.
- Updates to the same index apply in queue order. Each pop re-reads the table, so back-to-back same-index updates compose correctly.

## Timing
- Reset values:
  - `busy`=1, `tbl_we`=1, `tbl_addr`=0, `tbl_wdata`=0
  - `lookup_ready`=0, `upd_ready`=0, `qcount`=0, starve counter 0
- The sweep takes exactly 2**IWIDTH enabled cycles. The first cycle after the last sweep write is RUN.
- Lookup has zero-cycle latency: `lookup_hist` is valid in the grant cycle.
- A pushed update is poppable the cycle after the push.
- Starve counter:
  - Increments each enabled RUN cycle where the queue is non-empty and no pop occurs.
  - Clears on a pop, on an empty queue, and on `clear`.
  - force = counter ≥ STARVE.
- `en`=0 mid-sweep pauses the sweep, which resumes at the same address.
- `resetn` low mid-operation discards the queue immediately and restarts the sweep at 0.

## Configuration
- `BHT_SCHED_STARVE_EN` defined: the starvation guard is active as described above.
- Not defined: the counter is removed, force is always 0, and lookups have strict priority, so updates may starve indefinitely.

## Structure
- `bht_sched_pkg` holds:
  - the state enum (SWEEP, RUN)
  - the queue entry struct `upd_entry_t` {index, taken}, with widths passed as parameters to the typedef-owning module or fixed by package parameters
- The queue is one sub-module, `bht_upd_fifo`: synchronous FIFO with push/pop/flush, wrap-around pointers and a count output.

## Test plan
- Reset, then `resetn` high with `en`=1 → `busy`=1 for 64 cycles, writes to addresses 0..63 with data 0, then `busy`=0 and `upd_ready`=1.
- Push idx 5 taken=1 with no lookups; later push idx 5 taken=0 → `tbl_wdata`=6'b000001, then 6'b000010; a subsequent lookup of 5 returns 6'b000010.
- Fill queue with 4 updates → `qcount`=4 and `upd_ready`=0; a 5th offer is held. The first pop then raises `upd_ready` the following cycle.
- `lookup_valid` held high with 1 update queued (guard enabled, STARVE=8) → 8 lookup grants, then on the 9th cycle `lookup_ready`=0 and the update is written. With the macro undefined, the update is never written.
- `clear` with 3 queued updates in RUN → `qcount`=0 and `busy`=1 next cycle; a 64-cycle sweep follows and no queued update is ever written.
- `en`=0 for 5 cycles at sweep address 20 → `tbl_we`=0 throughout; the sweep resumes writing address 20.
